// File: rtl/div_pkg.sv
// Shared definitions for the sequential unsigned divider: FSM states and default widths.
package div_pkg;

    localparam int DIV_DW_DEFAULT = 16;
    localparam int DIV_VW_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_subtract_stage.sv
// One restoring-division step: compare the shifted partial remainder with the
// divisor, subtract when it fits and report the resulting quotient bit.
module div_subtract_stage #(
    parameter int VW = 8
) (
    input  logic [VW:0]   shifted,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   rem_next,
    output logic          q_bit
);

    logic [VW:0] divisor_ext_s;

    // Conditional subtract: keep the shifted value unless the divisor fits into it.
    always_comb begin
        divisor_ext_s = {1'b0, divisor};
        rem_next      = shifted;
        q_bit         = 1'b0;
        if (shifted >= divisor_ext_s) begin
            rem_next = shifted - divisor_ext_s;
            q_bit    = 1'b1;
        end else begin
            rem_next = shifted;
            q_bit    = 1'b0;
        end
    end

endmodule

// File: rtl/sequential_unsigned_divider.sv
// Multi-cycle restoring divider: one quotient bit per RUN cycle, MSB first.
// The quotient register doubles as the dividend shift register: dividend bits
// leave at the top while quotient bits enter at the bottom. DONE spans two
// cycles; the second one carries the registered done pulse, so done and busy
// always come straight from flops.
module sequential_unsigned_divider
    import div_pkg::*;
#(
    parameter int DW = DIV_DW_DEFAULT,
    parameter int VW = DIV_VW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dz
);

    localparam int RW = VW + 1;
    localparam int CW = $clog2(DW + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    div_state_e    state_r;
    div_state_e    state_s;
    logic [CW-1:0] cnt_r;
    logic [DW-1:0] quot_r;
    logic [RW-1:0] rem_r;
    logic [VW-1:0] divisor_r;
    logic          busy_r;
    logic          done_r;
    logic          dz_r;
    logic [RW-1:0] shifted_s;
    logic [RW-1:0] rem_next_s;
    logic          q_bit_s;

    // Next dividend bit enters the partial remainder; the top bit is always zero
    // between iterations because the stored remainder is below the divisor.
    assign shifted_s = RW'({rem_r, quot_r[DW-1]});

    div_subtract_stage #(
        .VW (VW)
    ) u_stage (
        .shifted  (shifted_s),
        .divisor  (divisor_r),
        .rem_next (rem_next_s),
        .q_bit    (q_bit_s)
    );

    // Next-state logic: IDLE -> RUN (or DONE on zero divisor) -> DONE (two cycles) -> IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (divisor == {VW{1'b0}}) begin
                        state_s = DONE;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (done_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs with synchronous reset priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            quot_r    <= {DW{1'b0}};
            rem_r     <= {RW{1'b0}};
            divisor_r <= {VW{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dz_r      <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_r == DONE) && !done_r;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        cnt_r     <= CNT_ZERO;
                        divisor_r <= divisor;
                        if (divisor == {VW{1'b0}}) begin
                            quot_r <= {DW{1'b1}};
                            rem_r  <= {1'b0, dividend[VW-1:0]};
                            dz_r   <= 1'b1;
                        end else begin
                            quot_r <= dividend;
                            rem_r  <= {RW{1'b0}};
                            dz_r   <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    quot_r <= {quot_r[DW-2:0], q_bit_s};
                    rem_r  <= rem_next_s;
                    cnt_r  <= cnt_r + CNT_ONE;
                end
                DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= CNT_ZERO;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = quot_r;
    assign remainder = rem_r[VW-1:0];
    assign dz        = dz_r;

endmodule

// File: tb/tb_sequential_unsigned_divider.sv
// Self-checking bench for sequential_unsigned_divider (DW=16, VW=8).
module tb_sequential_unsigned_divider;

    localparam int DW = 16;
    localparam int VW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          dz;

    int n_tests = 0;
    int n_fail  = 0;

    sequential_unsigned_divider #(.DW(DW), .VW(VW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: an accepted request fixes the answer by plain arithmetic
    // and the edge on which done must appear; busy covers acceptance through done.
    logic          m_valid = 1'b0;
    logic          m_busy  = 1'b0;
    int            edge_cnt = 0;
    int            m_done_edge = 0;
    logic [DW-1:0] m_a = '0;
    logic [VW-1:0] m_b = '0;
    logic [DW-1:0] m_q = '0;
    logic [VW-1:0] m_r = '0;
    logic          m_dz = 1'b0;

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (rst) begin
            m_valid <= 1'b1;
            m_busy  <= 1'b0;
            m_q     <= '0;
            m_r     <= '0;
            m_dz    <= 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1;
                m_a    <= dividend;
                m_b    <= divisor;
                if (divisor == 0) begin
                    m_q         <= '1;
                    m_r         <= dividend[VW-1:0];
                    m_dz        <= 1'b1;
                    m_done_edge <= edge_cnt + 2;
                end else begin
                    m_q         <= dividend / divisor;
                    m_r         <= VW'(dividend % divisor);
                    m_dz        <= 1'b0;
                    m_done_edge <= edge_cnt + DW + 2;
                end
            end
        end else if (edge_cnt == m_done_edge) begin
            m_busy <= 1'b0;
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        logic exp_done;
        if (m_valid) begin
            exp_done = m_busy && (edge_cnt == m_done_edge);
            check("done", done, exp_done);
            check("busy", busy, m_busy);
            if (exp_done || !m_busy) begin
                check("quotient", quotient, m_q);
                check("remainder", remainder, m_r);
                check("dz", dz, m_dz);
            end
            if (done && !dz && m_b != 0) begin
                check("identity", 64'(quotient) * 64'(m_b) + 64'(remainder), 64'(m_a));
                check("rem_lt_div", remainder < m_b, 1'b1);
            end
        end
    end

    // Single division with literal expectations for result, latency and busy length.
    task automatic run_div(input string name, input logic [DW-1:0] a, input logic [VW-1:0] b,
                           input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic edz,
                           input int elat, input int ebusy);
        int n = 0;
        int nb = 0;
        logic got = 1'b0;
        @(posedge clk); #1;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        while (n < 100 && !got) begin
            @(posedge clk); #1;
            start = 1'b0;
            n++;
            if (busy) nb++;
            if (done) got = 1'b1;
        end
        check({name, "_timeout"}, got, 1'b1);
        check({name, "_latency"}, 64'(n - 1), 64'(elat));
        check({name, "_busy_cycles"}, 64'(nb), 64'(ebusy));
        check({name, "_q"}, quotient, eq);
        check({name, "_r"}, remainder, er);
        check({name, "_dz"}, dz, edz);
        @(posedge clk); #1;
    endtask

    initial begin
        int dones;
        int cyc;
        logic got;
        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_q", quotient, 16'h0000);
        check("reset_r", remainder, 8'h00);
        check("reset_dz", dz, 1'b0);

        run_div("d100_7", 16'd100, 8'd7, 16'd14, 8'd2, 1'b0, 17, 18);
        run_div("dffff_ff", 16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 17, 18);
        run_div("d3_10", 16'd3, 8'd10, 16'd0, 8'd3, 1'b0, 17, 18);
        run_div("d5_0", 16'd5, 8'd0, 16'hFFFF, 8'd5, 1'b1, 1, 2);
        run_div("d65535_1", 16'hFFFF, 8'd1, 16'hFFFF, 8'd0, 1'b0, 17, 18);

        // Second start while busy must be ignored.
        @(posedge clk); #1;
        dividend = 16'd100; divisor = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 dividend = 16'd50; divisor = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            if (done) got = 1'b1;
        end
        check("ignore_timeout", got, 1'b1);
        check("ignore_q", quotient, 16'd14);
        check("ignore_r", remainder, 8'd2);
        @(posedge clk); #1;
        run_div("d50_5", 16'd50, 8'd5, 16'd10, 8'd0, 1'b0, 17, 18);

        // Reset in the middle of a division aborts it with no done pulse.
        @(posedge clk); #1;
        dividend = 16'hFFFF; divisor = 8'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_q", quotient, 16'h0000);
        check("abort_r", remainder, 8'h00);
        check("abort_dz", dz, 1'b0);
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        run_div("d9_4", 16'd9, 8'd4, 16'd2, 8'd1, 1'b0, 17, 18);

        // Back-to-back random requests with start held high and operands changing every cycle.
        dones = 0;
        cyc = 0;
        start = 1'b1;
        while (dones < 1000 && cyc < 25000) begin
            dividend = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 15) == 0) divisor = 8'd0;
            else divisor = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            cyc++;
            if (done) dones++;
        end
        start = 1'b0;
        check("random_done_count", 64'(dones), 64'd1000);
        repeat (25) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
